// File: rtl/fir_mac_20bit_if.sv
// rtl/fir_mac_20bit_if.sv - sample, coefficient and result signals of the FIR tap engine
interface fir_mac_20bit_if #(
  parameter int DATA_W = 20,
  parameter int COEF_W = 18,
  parameter int AW     = 3
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     coef_we;
  logic [AW-1:0]            coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_data;
  logic                     sat_flag;
  logic                     busy;

  modport master (
    output in_valid, in_data, coef_we, coef_addr, coef_data,
    input  in_ready, out_valid, out_data, sat_flag, busy
  );

  modport slave (
    input  in_valid, in_data, coef_we, coef_addr, coef_data,
    output in_ready, out_valid, out_data, sat_flag, busy
  );
endinterface

// File: rtl/fir_mac_20bit.sv
// rtl/fir_mac_20bit.sv - time-multiplexed FIR tap engine, one multiply per cycle
module fir_mac_20bit #(
  parameter int DATA_W    = 20,
  parameter int COEF_W    = 18,
  parameter int COEF_FRAC = 16,
  parameter int TAPS      = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  fir_mac_20bit_if.slave bus
);
  localparam int AW     = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = DATA_W + COEF_W + AW;

  localparam logic [AW-1:0] K_LAST = AW'(TAPS - 1);
  localparam logic signed [ACC_W-1:0] HALF =
    {{(ACC_W-COEF_FRAC){1'b0}}, 1'b1, {(COEF_FRAC-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, DRAIN, ROUND} state_t;

  state_t                   r_state;
  state_t                   w_next_state;
  logic                     w_ready;
  logic                     w_accept;
  logic                     w_coef_wr;

  logic signed [DATA_W-1:0] r_hist [TAPS];
  logic signed [COEF_W-1:0] r_coef [TAPS];
  logic [AW-1:0]            r_wr_ptr;
  logic [AW-1:0]            r_newest;
  logic [AW-1:0]            r_k;
  logic [AW-1:0]            w_idx;
  logic signed [PROD_W-1:0] r_prod;
  logic                     r_prod_vld;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [ACC_W-1:0]  w_rnd;
  logic signed [ACC_W-1:0]  w_shr;
  logic signed [DATA_W-1:0] w_clamped;
  logic                     w_sat;
  logic                     r_out_valid;
  logic signed [DATA_W-1:0] r_out_data;
  logic                     r_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_ready      = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (bus.in_valid) w_next_state = MAC;
      end
      MAC:     if (r_k == K_LAST) w_next_state = DRAIN;
      DRAIN:   w_next_state = ROUND;
      ROUND:   w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  assign w_accept  = w_ready && bus.in_valid;
  assign w_coef_wr = w_ready && bus.coef_we;

  // Tap k reads the sample k positions older than the one written at accept.
  assign w_idx = r_newest - r_k;

  // Round half toward +inf, then clamp into the sample range.
  always_comb begin
    w_rnd     = r_acc + HALF;
    w_shr     = w_rnd >>> COEF_FRAC;
    w_sat     = 1'b0;
    w_clamped = w_shr[DATA_W-1:0];
    if (w_shr > SAT_MAX) begin
      w_sat     = 1'b1;
      w_clamped = SAT_MAX[DATA_W-1:0];
    end else if (w_shr < SAT_MIN) begin
      w_sat     = 1'b1;
      w_clamped = SAT_MIN[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        r_hist[i] <= '0;
        r_coef[i] <= '0;
      end
      r_wr_ptr    <= '0;
      r_newest    <= '0;
      r_k         <= '0;
      r_prod      <= '0;
      r_prod_vld  <= 1'b0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_sat       <= 1'b0;
    end else begin
      if (w_coef_wr) r_coef[bus.coef_addr] <= bus.coef_data;
      if (w_accept) begin
        r_hist[r_wr_ptr] <= bus.in_data;
        r_newest         <= r_wr_ptr;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
        r_k              <= '0;
      end
      if (r_state == MAC) begin
        r_prod <= r_hist[w_idx] * r_coef[r_k];
        r_k    <= r_k + 1'b1;
      end
      r_prod_vld <= (r_state == MAC);
      if (w_accept) begin
        r_acc <= '0;
      end else if (r_prod_vld) begin
        r_acc <= r_acc + {{AW{r_prod[PROD_W-1]}}, r_prod};
      end
      r_out_valid <= (r_state == ROUND);
      if (r_state == ROUND) begin
        r_out_data <= w_clamped;
        r_sat      <= w_sat;
      end
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.busy      = !w_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.sat_flag  = r_sat;
endmodule
